// File: rtl/axist_gpio_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : axist_gpio_test_seq
//  Purpose  : Management-side test sequencer for the AXI-ST GPIO loopback.
//             On i_start it waits for both link directions to report online,
//             programs the delay X/Y/Z registers and the pattern-generator
//             control word over an Avalon-MM master port, then polls the
//             checker status word until it reports done. The result is
//             latched as a sticky pass/fail (or timeout) flag.
//  Ports    : clk, rst_n                  - clock, async active-low reset
//             i_start                     - one-cycle run request
//             i_delay_x/_y/_z, i_ctrl_word - values written during the run
//             i_tx_online, i_rx_online    - link status
//             o_address, o_wrdata, o_wren, o_rden,
//             i_waitreq, i_readdatavalid, i_readdata - AVMM master
//             o_busy, o_pass, o_fail, o_timeout      - run status
//  Config   : `define AXIST_SEQ_TIMEOUT_EN to build the run watchdog
//             (TIMEOUT_CYC busy cycles). Without it o_timeout is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module axist_gpio_test_seq #(
  parameter logic [31:0] ADDR_DELAY_X = 32'h0000_1000,
  parameter logic [31:0] ADDR_DELAY_Y = 32'h0000_1004,
  parameter logic [31:0] ADDR_DELAY_Z = 32'h0000_1008,
  parameter logic [31:0] ADDR_CTRL    = 32'h0000_100C,
  parameter logic [31:0] ADDR_STATUS  = 32'h0000_1010,
  parameter logic [31:0] TIMEOUT_CYC  = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_delay_x,
  input  logic [31:0] i_delay_y,
  input  logic [31:0] i_delay_z,
  input  logic [31:0] i_ctrl_word,
  input  logic        i_tx_online,
  input  logic        i_rx_online,
  output logic [31:0] o_address,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic        i_waitreq,
  input  logic        i_readdatavalid,
  input  logic [31:0] i_readdata,
  output logic        o_busy,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_ONLINE = 3'd1,
    S_WR_REQ      = 3'd2,
    S_RD_REQ      = 3'd3,
    S_RD_WAIT     = 3'd4,
    S_PASS        = 3'd5,
    S_FAIL        = 3'd6,
    S_TMO         = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wr_idx;
  logic [1:0]  w_wr_idx_nxt;
  // r_gap marks the single idle cycle inserted between AVMM transfers; the
  // request states hold their strobe low while it is set.
  logic        r_gap;
  logic        w_gap_nxt;

  logic [31:0] r_delay_x;
  logic [31:0] r_delay_y;
  logic [31:0] r_delay_z;
  logic [31:0] r_ctrl;

  logic        w_busy;
  logic        w_start;
  logic        w_wr_stb;
  logic        w_rd_stb;
  logic        w_timeout;
  logic [31:0] w_wr_addr;
  logic [31:0] w_wr_data;

  // Only the {done, pass} bits of the status word carry meaning here.
  logic        w_unused_rdata;
  assign w_unused_rdata = &{1'b0, i_readdata[31:2]};

  assign w_busy   = (r_state == S_WAIT_ONLINE) || (r_state == S_WR_REQ) ||
                    (r_state == S_RD_REQ)      || (r_state == S_RD_WAIT);
  assign w_start  = i_start && !w_busy;
  assign w_wr_stb = (r_state == S_WR_REQ) && !r_gap;
  assign w_rd_stb = (r_state == S_RD_REQ) && !r_gap;

  // --------------------------------------------------------------------------
  // Optional run watchdog: counts busy cycles since the accepted i_start and
  // forces the timeout state on the cycle the count reaches TIMEOUT_CYC.
  // --------------------------------------------------------------------------
`ifdef AXIST_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_start) begin
      r_wdog <= '0;
    end else if (w_busy) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  assign w_timeout = w_busy && (r_wdog == (TIMEOUT_CYC - 32'd1));
  assign o_timeout = (r_state == S_TMO);
`else
  assign w_timeout = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Register-programming table, indexed by the write counter.
  always_comb begin
    w_wr_addr = ADDR_DELAY_X;
    w_wr_data = r_delay_x;
    case (r_wr_idx)
      2'd0: begin
        w_wr_addr = ADDR_DELAY_X;
        w_wr_data = r_delay_x;
      end
      2'd1: begin
        w_wr_addr = ADDR_DELAY_Y;
        w_wr_data = r_delay_y;
      end
      2'd2: begin
        w_wr_addr = ADDR_DELAY_Z;
        w_wr_data = r_delay_z;
      end
      default: begin
        w_wr_addr = ADDR_CTRL;
        w_wr_data = r_ctrl;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx_nxt = r_wr_idx;
    w_gap_nxt    = 1'b0;

    case (r_state)
      S_IDLE, S_PASS, S_FAIL, S_TMO: begin
        if (w_start) begin
          w_state_nxt  = S_WAIT_ONLINE;
          w_wr_idx_nxt = 2'd0;
        end
      end

      S_WAIT_ONLINE: begin
        if (i_tx_online && i_rx_online) begin
          w_state_nxt = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (w_wr_stb && !i_waitreq) begin
          w_gap_nxt = 1'b1;
          if (r_wr_idx == 2'd3) begin
            w_state_nxt  = S_RD_REQ;
            w_wr_idx_nxt = 2'd0;
          end else begin
            w_wr_idx_nxt = r_wr_idx + 2'd1;
          end
        end
      end

      S_RD_REQ: begin
        if (w_rd_stb && !i_waitreq) begin
          w_state_nxt = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (i_readdatavalid) begin
          case (i_readdata[1:0])
            2'b11:   w_state_nxt = S_PASS;
            2'b10:   w_state_nxt = S_FAIL;
            default: begin
              // Checker not done yet: poll again after an idle cycle.
              w_state_nxt = S_RD_REQ;
              w_gap_nxt   = 1'b1;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // The watchdog wins over any transfer in flight.
    if (w_timeout) begin
      w_state_nxt  = S_TMO;
      w_wr_idx_nxt = 2'd0;
      w_gap_nxt    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State and run registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_idx <= 2'd0;
      r_gap    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  // Write values are captured at the accepted start so the run is immune to
  // the inputs changing while it is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_x <= '0;
      r_delay_y <= '0;
      r_delay_z <= '0;
      r_ctrl    <= '0;
    end else if (w_start) begin
      r_delay_x <= i_delay_x;
      r_delay_y <= i_delay_y;
      r_delay_z <= i_delay_z;
      r_ctrl    <= i_ctrl_word;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registers only, so reset clears them at once and
  // they stay stable across a waitrequest stall.
  // --------------------------------------------------------------------------
  assign o_wren    = w_wr_stb;
  assign o_rden    = w_rd_stb;
  assign o_address = w_wr_stb ? w_wr_addr :
                     (w_rd_stb ? ADDR_STATUS : 32'd0);
  assign o_wrdata  = w_wr_stb ? w_wr_data : 32'd0;
  assign o_busy    = w_busy;
  assign o_pass    = (r_state == S_PASS);
  assign o_fail    = (r_state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_axist_gpio_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axist_gpio_test_seq
//  Purpose  : Self-checking bench for axist_gpio_test_seq. A reactive AVMM
//             slave with random waitrequest, read latency and stray
//             readdatavalid pulses feeds a transaction-level reference model
//             that checks every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axist_gpio_test_seq;

  localparam logic [31:0] TB_TMO = 32'd200;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_delay_x;
  logic [31:0] i_delay_y;
  logic [31:0] i_delay_z;
  logic [31:0] i_ctrl_word;
  logic        i_tx_online;
  logic        i_rx_online;
  logic [31:0] o_address;
  logic [31:0] o_wrdata;
  logic        o_wren;
  logic        o_rden;
  logic        i_waitreq;
  logic        i_readdatavalid;
  logic [31:0] i_readdata;
  logic        o_busy;
  logic        o_pass;
  logic        o_fail;
  logic        o_timeout;

  axist_gpio_test_seq #(
    .TIMEOUT_CYC (TB_TMO)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_delay_x       (i_delay_x),
    .i_delay_y       (i_delay_y),
    .i_delay_z       (i_delay_z),
    .i_ctrl_word     (i_ctrl_word),
    .i_tx_online     (i_tx_online),
    .i_rx_online     (i_rx_online),
    .o_address       (o_address),
    .o_wrdata        (o_wrdata),
    .o_wren          (o_wren),
    .o_rden          (o_rden),
    .i_waitreq       (i_waitreq),
    .i_readdatavalid (i_readdatavalid),
    .i_readdata      (i_readdata),
    .o_busy          (o_busy),
    .o_pass          (o_pass),
    .o_fail          (o_fail),
    .o_timeout       (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          busy_exp, exp_pass, exp_fail, exp_tmo;
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];
  logic [31:0] wr_log_addr [4];
  logic [31:0] wr_log_data [4];
  int          wr_hold [4];
  int          wr_n, rd_n, busy_cnt, cyc, last_evt, online_cyc, hold_cnt;
  bit          evt_pending, online_seen;
  logic        p_wren, p_rden;
  logic [31:0] p_addr, p_data;

  // ---------------- slave configuration / state ----------------
  logic [1:0]  resp_q [$];
  bit          outstanding, rv_real, rd_hold, junk_en;
  int          rv_delay, stall_idx, stall_len, stall_cnt, stall_pct;
  logic [31:0] dx, dy, dz, dc;

  task automatic model_reset();
    busy_exp    = 1'b0;
    exp_pass    = 1'b0;
    exp_fail    = 1'b0;
    exp_tmo     = 1'b0;
    outstanding = 1'b0;
    rv_real     = 1'b0;
    evt_pending = 1'b0;
    p_wren      = 1'b0;
    p_rden      = 1'b0;
    p_addr      = '0;
    p_data      = '0;
    hold_cnt    = 0;
  endtask

  // ---------------- monitor / model / reactive slave ----------------
  initial begin : monitor
    bit          start_ev, tmo_ev, cpl_now, stall_ev, w, strobe_now, p_strobe;
    logic [31:0] rnd;
    logic [1:0]  code;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      cpl_now  = 1'b0;
      stall_ev = 1'b0;
      if (!rst_n) begin
        model_reset();
      end else begin
        start_ev = i_start && !busy_exp;
        tmo_ev   = 1'b0;
`ifdef AXIST_SEQ_TIMEOUT_EN
        if (busy_exp) begin
          if (busy_cnt == int'(TB_TMO) - 1) tmo_ev = 1'b1;
          else busy_cnt++;
        end
`endif
        if (tmo_ev) begin
          busy_exp    = 1'b0;
          exp_tmo     = 1'b1;
          outstanding = 1'b0;
          rv_real     = 1'b0;
          cpl_now     = 1'b1;
        end else begin
          stall_ev = (p_wren || p_rden) && i_waitreq;
          if (p_wren && !i_waitreq) begin
            cpl_now = 1'b1;
            if (wr_n < 4) begin
              chk("wr_addr", p_addr, exp_addr[wr_n]);
              chk("wr_data", p_data, exp_data[wr_n]);
              wr_log_addr[wr_n] = p_addr;
              wr_log_data[wr_n] = p_data;
              wr_hold[wr_n]     = hold_cnt;
            end else begin
              chk("wr_excess_count", 32'(wr_n), 32'd3);
            end
            chk("wr_before_rd", 32'(rd_n), 32'd0);
            wr_n++;
            last_evt    = cyc;
            evt_pending = 1'b1;
          end
          if (p_rden && !i_waitreq) begin
            cpl_now = 1'b1;
            chk("rd_addr", p_addr, 32'h0000_1010);
            chk("rd_after_4wr", 32'(wr_n), 32'd4);
            rd_n++;
            outstanding = 1'b1;
            rv_delay    = $urandom_range(0, 2);
          end
          if (i_readdatavalid && rv_real) begin
            rv_real     = 1'b0;
            outstanding = 1'b0;
            last_evt    = cyc;
            evt_pending = 1'b1;
            if (i_readdata[1]) begin
              busy_exp = 1'b0;
              exp_pass = i_readdata[0];
              exp_fail = !i_readdata[0];
            end
          end
          if (busy_exp && !online_seen && i_tx_online && i_rx_online) begin
            online_seen = 1'b1;
            online_cyc  = cyc;
          end
        end
        if (start_ev) begin
          busy_exp    = 1'b1;
          exp_pass    = 1'b0;
          exp_fail    = 1'b0;
          exp_tmo     = 1'b0;
          exp_addr[0] = 32'h0000_1000; exp_data[0] = i_delay_x;
          exp_addr[1] = 32'h0000_1004; exp_data[1] = i_delay_y;
          exp_addr[2] = 32'h0000_1008; exp_data[2] = i_delay_z;
          exp_addr[3] = 32'h0000_100C; exp_data[3] = i_ctrl_word;
          wr_n        = 0;
          rd_n        = 0;
          busy_cnt    = 0;
          online_seen = 1'b0;
          evt_pending = 1'b0;
        end
      end

      #1;
      if (rst_n) begin
        strobe_now = o_wren || o_rden;
        p_strobe   = p_wren || p_rden;
        chk("busy", 32'(o_busy), 32'(busy_exp));
        chk("pass_flag", 32'(o_pass), 32'(exp_pass));
        chk("fail_flag", 32'(o_fail), 32'(exp_fail));
        chk("timeout_flag", 32'(o_timeout), 32'(exp_tmo));
        chk("wren_rden_excl", 32'(o_wren && o_rden), 32'd0);
        if (!busy_exp) chk("strobe_when_idle", 32'(strobe_now), 32'd0);
        if (busy_exp && !online_seen) chk("strobe_before_online", 32'(strobe_now), 32'd0);
        if (cpl_now) chk("strobe_drop_after_cpl", 32'(strobe_now), 32'd0);
        if (stall_ev) begin
          chk("stall_wren", 32'(o_wren), 32'(p_wren));
          chk("stall_rden", 32'(o_rden), 32'(p_rden));
          chk("stall_addr", o_address, p_addr);
          chk("stall_data", o_wrdata, p_data);
        end
        if (strobe_now && !p_strobe) begin
          if (evt_pending) begin
            chk("idle_gap", 32'(cyc - last_evt), 32'd1);
          end else begin
            chk("online_before_strobe", 32'(online_seen), 32'd1);
            chk("online_latency_le2", 32'((cyc - online_cyc) <= 2), 32'd1);
          end
          evt_pending = 1'b0;
        end
        if (strobe_now) hold_cnt = (!p_strobe || cpl_now) ? 1 : hold_cnt + 1;

        // drive the slave side for the current cycle
        w = 1'b0;
        if (o_wren && wr_n == stall_idx && stall_cnt < stall_len) begin
          w = 1'b1;
          stall_cnt++;
        end else if (o_rden && rd_hold) begin
          w = 1'b1;
        end else if (strobe_now) begin
          w = ($urandom_range(0, 99) < stall_pct);
        end else begin
          w = ($urandom_range(0, 1) == 1);
        end
        i_waitreq = w;
        rnd = $urandom();
        if (outstanding) begin
          if (rv_delay == 0) begin
            code = 2'b00;
            if (resp_q.size() > 0) code = resp_q.pop_front();
            i_readdata      = rnd;
            i_readdata[1:0] = code;
            i_readdatavalid = 1'b1;
            rv_real         = 1'b1;
            rv_delay        = -1;
          end else begin
            if (rv_delay > 0) rv_delay--;
            i_readdata      = rnd | 32'd3;
            i_readdatavalid = 1'b0;
            rv_real         = 1'b0;
          end
        end else begin
          i_readdata      = rnd | 32'd3;
          i_readdatavalid = junk_en && (rnd[4:2] == 3'd0);
          rv_real         = 1'b0;
        end
        p_wren = o_wren;
        p_rden = o_rden;
        p_addr = o_address;
        p_data = o_wrdata;
      end else begin
        i_waitreq       = 1'b0;
        i_readdatavalid = 1'b0;
        i_readdata      = '0;
      end
    end
  end

  // ---------------- one complete run ----------------
  task automatic do_run(input int offline, input int s_idx, input int s_len, input int s_pct,
                        input bit drop, input int exp_reads, input bit exp_p);
    int n;
    @(negedge clk);
    dx = $urandom(); dy = $urandom(); dz = $urandom(); dc = $urandom();
    i_delay_x = dx; i_delay_y = dy; i_delay_z = dz; i_ctrl_word = dc;
    stall_idx = s_idx; stall_len = s_len; stall_cnt = 0; stall_pct = s_pct;
    i_tx_online = 1'b1;
    i_rx_online = (offline == 0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_delay_x = $urandom(); i_delay_y = $urandom();
    i_delay_z = $urandom(); i_ctrl_word = $urandom();
    @(negedge clk);
    if (o_busy) i_start = 1'b1;   // must be ignored
    @(negedge clk);
    i_start = 1'b0;
    if (offline > 3) repeat (offline - 3) @(negedge clk);
    i_rx_online = 1'b1;
    n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
      if (drop && online_seen) begin
        i_tx_online = ($urandom_range(0, 1) == 1);
        i_rx_online = ($urandom_range(0, 1) == 1);
      end
    end
    i_tx_online = 1'b1;
    i_rx_online = 1'b1;
    chk("run_completes_in_budget", 32'(n < 3000), 32'd1);
    chk("write_count", 32'(wr_n), 32'd4);
    chk("read_count", 32'(rd_n), 32'(exp_reads));
    chk("end_pass", 32'(o_pass), 32'(exp_p));
    chk("end_fail", 32'(o_fail), 32'(!exp_p));
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("lit_addr_y", wr_log_addr[1], 32'h0000_1004);
    chk("lit_addr_ctrl", wr_log_addr[3], 32'h0000_100C);
    chk("lit_data_x", wr_log_data[0], dx);
    chk("lit_data_y", wr_log_data[1], dy);
    chk("lit_data_z", wr_log_data[2], dz);
    chk("lit_data_ctrl", wr_log_data[3], dc);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int n, npoll;
    logic fb;
    rst_n = 1'b0; i_start = 1'b0;
    i_delay_x = '0; i_delay_y = '0; i_delay_z = '0; i_ctrl_word = '0;
    i_tx_online = 1'b0; i_rx_online = 1'b0;
    i_waitreq = 1'b0; i_readdatavalid = 1'b0; i_readdata = '0;
    stall_idx = -1; stall_len = 0; stall_cnt = 0; stall_pct = 0;
    rd_hold = 1'b0; junk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_address", o_address, 32'd0);
    chk("rst_wrdata", o_wrdata, 32'd0);
    chk("rst_wren", 32'(o_wren), 32'd0);
    chk("rst_rden", 32'(o_rden), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_flags", 32'({o_pass, o_fail, o_timeout}), 32'd0);

    // straight pass on first poll
    resp_q = '{2'b11};
    do_run(0, -1, 0, 0, 1'b0, 1, 1'b1);

    // 5-cycle stall on the second write
    resp_q = '{2'b11};
    do_run(0, 1, 5, 0, 1'b0, 1, 1'b1);
    chk("stall_hold_cycles", 32'(wr_hold[1]), 32'd6);
    chk("nostall_hold_cycles", 32'(wr_hold[2]), 32'd1);

    // two not-done polls then fail
    resp_q = '{2'b00, 2'b00, 2'b10};
    do_run(0, -1, 0, 20, 1'b0, 3, 1'b0);

    // receive side offline for 50 cycles
    resp_q = '{2'b11};
    do_run(50, -1, 0, 20, 1'b0, 1, 1'b1);

    // randomized runs with link drops mid-run
    for (int r = 0; r < 10; r++) begin
      resp_q.delete();
      npoll = $urandom_range(0, 3);
      for (int k = 0; k < npoll; k++) resp_q.push_back({1'b0, 1'($urandom_range(0, 1))});
      fb = 1'($urandom_range(0, 1));
      resp_q.push_back({1'b1, fb});
      do_run(int'($urandom_range(0, 6)), -1, 0, 30, 1'b1, npoll + 1, fb);
    end

    // reset while a read request is held off by waitrequest
    resp_q.delete();
    rd_hold = 1'b1;
    stall_pct = 0;
    stall_idx = -1;
    @(negedge clk);
    i_tx_online = 1'b1; i_rx_online = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!o_rden && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rd_reached_before_reset", 32'(o_rden), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rden", 32'(o_rden), 32'd0);
    chk("async_rst_wren", 32'(o_wren), 32'd0);
    chk("async_rst_address", o_address, 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_hold = 1'b0;
    resp_q = '{2'b11};
    do_run(0, -1, 0, 20, 1'b0, 1, 1'b1);

`ifdef AXIST_SEQ_TIMEOUT_EN
    // watchdog: status never reports done
    resp_q.delete();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (o_busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_busy_cycles", 32'(n), TB_TMO);
    chk("tmo_flag_set", 32'(o_timeout), 32'd1);
    chk("tmo_strobes_low", 32'(o_wren || o_rden), 32'd0);
    resp_q = '{2'b11};
    do_run(0, -1, 0, 0, 1'b0, 1, 1'b1);
    chk("tmo_cleared_by_start", 32'(o_timeout), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_limit
    #2ms;
    failures++;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
